// File: rtl/spi_2_cmd_sequencer_if.sv
// Command, response and SPI-master driver bus of the instruction sequencer.
//   cmd_*        host -> sequencer instruction words (valid/ready)
//   rsp_*        sequencer -> host captured read responses (valid/ready)
//   driver_*     sequencer <-> SPI master word hand-off and latched mode
//   spi_slv_read_data  read data returned by the master for the previous word
// Modport slave is the sequencer side, master is the host/SPI-master side.
interface spi_2_cmd_sequencer_if #(
    parameter int unsigned DWIDTH       = 8,
    parameter int unsigned AWIDTH       = 8,
    parameter int unsigned S_ADDR_WIDTH = 2
);
    localparam int unsigned IW = S_ADDR_WIDTH + 1 + 2 + AWIDTH + DWIDTH;

    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [IW-1:0]           cmd_data;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DWIDTH-1:0]       rsp_data;
    logic [AWIDTH-1:0]       rsp_addr;
    logic [S_ADDR_WIDTH-1:0] rsp_ss;
    logic                    driver_read;
    logic [IW-1:0]           driver_data;
    logic [1:0]              driver_cfg;
    logic [DWIDTH-1:0]       spi_slv_read_data;

    modport slave (
        input  cmd_valid, cmd_data, rsp_ready, driver_read, spi_slv_read_data,
        output cmd_ready, rsp_valid, rsp_data, rsp_addr, rsp_ss, driver_data, driver_cfg
    );

    modport master (
        output cmd_valid, cmd_data, rsp_ready, driver_read, spi_slv_read_data,
        input  cmd_ready, rsp_valid, rsp_data, rsp_addr, rsp_ss, driver_data, driver_cfg
    );
endinterface

// File: rtl/spi_2_cmd_sequencer.sv
// Instruction sequencer feeding an SPI master from a command FIFO and capturing
// read data into a response FIFO, with credit-based pause/resume and abort.
//   clk, rst_n         clock, asynchronous active-low reset
//   start, abort       begin issuing / stop and flush commands
//   cfg_in             SPI mode, latched into driver_cfg on accepted start
//   cmd_level, rsp_level  FIFO occupancies
//   busy, done, master_en  status, completion pulse, SPI master enable
//   bus                command/response/driver bus (slave modport)
module spi_2_cmd_sequencer #(
    parameter int unsigned DWIDTH       = 8,
    parameter int unsigned AWIDTH       = 8,
    parameter int unsigned S_ADDR_WIDTH = 2,
    parameter int unsigned CMD_DEPTH    = 8,
    parameter int unsigned RSP_DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic [1:0]                   cfg_in,
    output logic [$clog2(CMD_DEPTH):0]   cmd_level,
    output logic [$clog2(RSP_DEPTH):0]   rsp_level,
    output logic                         busy,
    output logic                         done,
    output logic                         master_en,
    spi_2_cmd_sequencer_if.slave         bus
);
    localparam int unsigned IW     = S_ADDR_WIDTH + 1 + 2 + AWIDTH + DWIDTH;
    localparam int unsigned RW     = S_ADDR_WIDTH + AWIDTH + DWIDTH;
    localparam int unsigned CAW    = $clog2(CMD_DEPTH);
    localparam int unsigned RAW    = $clog2(RSP_DEPTH);
    localparam int unsigned RSW    = RAW + 2;
    localparam int unsigned WR_BIT = DWIDTH + AWIDTH + 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]              state_q, state_d;
    logic                    master_en_q, master_en_d;
    logic [1:0]              cfg_q, cfg_d;
    logic                    done_q, done_d;
    logic                    busy_q;
    logic                    pend_rd_q, pend_rd_d;
    logic [S_ADDR_WIDTH-1:0] pend_ss_q, pend_ss_d;
    logic [AWIDTH-1:0]       pend_addr_q, pend_addr_d;

    logic [IW-1:0]           cmd_mem [CMD_DEPTH];
    logic [CAW-1:0]          cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d;
    logic [CAW:0]            cmd_cnt_q, cmd_cnt_d;
    logic                    cmd_ready_q;
    logic [RW-1:0]           rsp_mem [RSP_DEPTH];
    logic [RAW-1:0]          rsp_wr_q, rsp_wr_d, rsp_rd_q, rsp_rd_d;
    logic [RAW:0]            rsp_cnt_q, rsp_cnt_d;
    logic                    rsp_valid_q;

    logic                    cmd_push_c, cmd_pop_c, rsp_push_c, rsp_pop_c;
    logic                    cmd_empty_c, issuable_c, event_c;
    logic [IW-1:0]           cmd_head_c;
    logic [RW-1:0]           rsp_head_c;

    assign cmd_empty_c = (cmd_cnt_q == '0);
    assign cmd_head_c  = cmd_empty_c ? '0 : cmd_mem[cmd_rd_q];
    assign rsp_head_c  = rsp_valid_q ? rsp_mem[rsp_rd_q] : '0;
    assign event_c     = bus.driver_read & master_en_q;
    assign cmd_push_c  = bus.cmd_valid & cmd_ready_q & ~abort;
    assign rsp_pop_c   = bus.rsp_ready & rsp_valid_q;

    // Writes always issue; a read needs a free response slot counting the one in flight.
    assign issuable_c = ~cmd_empty_c &
                        (cmd_head_c[WR_BIT] |
                         ((RSW'(rsp_cnt_q) + RSW'(pend_rd_q)) < RSW'(RSP_DEPTH)));

    // Sequencer FSM: issue, capture, pause on credit, abort
    always_comb begin
        state_d     = state_q;
        master_en_d = master_en_q;
        cfg_d       = cfg_q;
        done_d      = 1'b0;
        pend_rd_d   = pend_rd_q;
        pend_ss_d   = pend_ss_q;
        pend_addr_d = pend_addr_q;
        cmd_pop_c   = 1'b0;
        rsp_push_c  = 1'b0;
        if (abort) begin
            master_en_d = 1'b0;
            pend_rd_d   = 1'b0;
            state_d     = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !cmd_empty_c) begin
                        state_d     = S_RUN;
                        cfg_d       = cfg_in;
                        master_en_d = 1'b1;
                    end
                end
                S_RUN: begin
                    if (event_c) begin
                        rsp_push_c = pend_rd_q;
                        if (issuable_c) begin
                            cmd_pop_c   = 1'b1;
                            pend_rd_d   = ~cmd_head_c[WR_BIT];
                            pend_ss_d   = cmd_head_c[IW-1 -: S_ADDR_WIDTH];
                            pend_addr_d = cmd_head_c[DWIDTH +: AWIDTH];
                        end else begin
                            pend_rd_d   = 1'b0;
                            master_en_d = 1'b0;
                            state_d     = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (cmd_empty_c) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else if (issuable_c) begin
                        master_en_d = 1'b1;
                        state_d     = S_RUN;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FIFO pointer and occupancy next state; abort empties the command side
    always_comb begin
        cmd_wr_d  = cmd_wr_q;
        cmd_rd_d  = cmd_rd_q;
        cmd_cnt_d = cmd_cnt_q;
        if (abort) begin
            cmd_wr_d  = '0;
            cmd_rd_d  = '0;
            cmd_cnt_d = '0;
        end else begin
            if (cmd_push_c) cmd_wr_d = cmd_wr_q + CAW'(1);
            if (cmd_pop_c)  cmd_rd_d = cmd_rd_q + CAW'(1);
            cmd_cnt_d = cmd_cnt_q + (CAW+1)'(cmd_push_c) - (CAW+1)'(cmd_pop_c);
        end
        rsp_wr_d  = rsp_push_c ? rsp_wr_q + RAW'(1) : rsp_wr_q;
        rsp_rd_d  = rsp_pop_c  ? rsp_rd_q + RAW'(1) : rsp_rd_q;
        rsp_cnt_d = rsp_cnt_q + (RAW+1)'(rsp_push_c) - (RAW+1)'(rsp_pop_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            master_en_q <= 1'b0;
            cfg_q       <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            pend_rd_q   <= 1'b0;
            pend_ss_q   <= '0;
            pend_addr_q <= '0;
            cmd_wr_q    <= '0;
            cmd_rd_q    <= '0;
            cmd_cnt_q   <= '0;
            cmd_ready_q <= 1'b0;
            rsp_wr_q    <= '0;
            rsp_rd_q    <= '0;
            rsp_cnt_q   <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            master_en_q <= master_en_d;
            cfg_q       <= cfg_d;
            done_q      <= done_d;
            busy_q      <= (state_d != S_IDLE);
            pend_rd_q   <= pend_rd_d;
            pend_ss_q   <= pend_ss_d;
            pend_addr_q <= pend_addr_d;
            cmd_wr_q    <= cmd_wr_d;
            cmd_rd_q    <= cmd_rd_d;
            cmd_cnt_q   <= cmd_cnt_d;
            cmd_ready_q <= (cmd_cnt_d != (CAW+1)'(CMD_DEPTH));
            rsp_wr_q    <= rsp_wr_d;
            rsp_rd_q    <= rsp_rd_d;
            rsp_cnt_q   <= rsp_cnt_d;
            rsp_valid_q <= (rsp_cnt_d != '0);
        end
    end

    // FIFO storage; contents are masked by the occupancy counts so need no reset
    always_ff @(posedge clk) begin
        if (cmd_push_c) cmd_mem[cmd_wr_q] <= bus.cmd_data;
        if (rsp_push_c) rsp_mem[rsp_wr_q] <= {pend_ss_q, pend_addr_q, bus.spi_slv_read_data};
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_ss      = rsp_head_c[RW-1 -: S_ADDR_WIDTH];
    assign bus.rsp_addr    = rsp_head_c[DWIDTH +: AWIDTH];
    assign bus.rsp_data    = rsp_head_c[DWIDTH-1:0];
    assign bus.driver_data = cmd_head_c;
    assign bus.driver_cfg  = cfg_q;
    assign cmd_level       = cmd_cnt_q;
    assign rsp_level       = rsp_cnt_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign master_en       = master_en_q;
endmodule
